// File: rtl/ula_ctrl_md.sv
// ula_ctrl_md: ALU control decode plus a sequential multiply/divide engine
// that owns HI/LO and stalls the pipeline while it iterates.
module ula_ctrl_md #(
  parameter int WIDTH     = 32,
  parameter int MD_ENABLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       ALU_Operation,
  output logic             illegal,
  output logic             stall,
  output logic             md_busy,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_opB;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_isDiv;
  logic               r_negQ;
  logic               r_negR;

  logic               w_mdEn;
  logic               w_rtype;
  logic               w_isMd;
  logic               w_isMf;
  logic               w_isMt;
  logic               w_unknown;
  logic               w_busy;
  logic               w_stall;
  logic               w_accept;
  logic               w_mtWrite;
  logic               w_signed;
  logic               w_isDivOp;
  logic               w_rsNeg;
  logic               w_rtNeg;
  logic               w_divZero;
  logic [WIDTH-1:0]   w_rsMag;
  logic [WIDTH-1:0]   w_rtMag;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_prodSigned;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;

  // With the engine disabled every MD/MF/MT funct falls through to illegal
  assign w_mdEn  = (MD_ENABLE != 0);
  assign w_rtype = (ALUOp == 3'b010);
  assign w_isMd  = w_mdEn && (funct[5:2] == 4'b0110);
  assign w_isMf  = w_mdEn && (funct[5:2] == 4'b0100) && !funct[0];
  assign w_isMt  = w_mdEn && (funct[5:2] == 4'b0100) && funct[0];

  assign w_busy    = w_mdEn && (r_state != S_IDLE);
  assign w_stall   = valid && w_rtype && (w_isMd || w_isMf || w_isMt) && w_busy;
  assign w_accept  = valid && w_rtype && w_isMd && !w_stall;
  assign w_mtWrite = valid && w_rtype && w_isMt && !w_stall;

  assign stall   = w_stall;
  assign md_busy = w_busy;
  assign hi_out  = r_hi;
  assign lo_out  = r_lo;
  assign mf_data = (valid && w_rtype && w_isMf && !w_stall) ? (funct[1] ? r_lo : r_hi)
                                                             : '0;

  // Operand preparation: odd funct is the unsigned flavour, bit 1 selects divide
  assign w_signed  = !funct[0];
  assign w_isDivOp = funct[1];
  assign w_rsNeg   = w_signed && rs_val[WIDTH-1];
  assign w_rtNeg   = w_signed && rt_val[WIDTH-1];
  assign w_rsMag   = w_rsNeg ? -rs_val : rs_val;
  assign w_rtMag   = w_rtNeg ? -rt_val : rt_val;
  assign w_divZero = w_isDivOp && (rt_val == '0);

  // Shift-add step: low half holds the multiplier, high half accumulates
  assign w_addend = r_prod[0] ? {1'b0, r_opB} : '0;
  assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;

  // Restoring divide step: high half is the remainder, low half shifts in quotient bits
  assign w_remShift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_opB};

  assign w_quo        = r_prod[WIDTH-1:0];
  assign w_rem        = r_prod[2*WIDTH-1:WIDTH];
  assign w_prodSigned = r_negQ ? -r_prod : r_prod;

  // Sign fix-up applied in FIX before HI/LO are written
  always_comb begin
    w_fixHi = w_prodSigned[2*WIDTH-1:WIDTH];
    w_fixLo = w_prodSigned[WIDTH-1:0];
    if (r_isDiv) begin
      w_fixLo = r_negQ ? -w_quo : w_quo;
      w_fixHi = r_negR ? -w_rem : w_rem;
    end
  end

  // ALU operation decode; unknown R-type functs give ADD code and flag illegal
  always_comb begin
    ALU_Operation = 4'h0;
    w_unknown     = 1'b0;
    case (ALUOp)
      3'b000, 3'b011: ALU_Operation = 4'h0;
      3'b001:         ALU_Operation = 4'h1;
      3'b100:         ALU_Operation = 4'h2;
      3'b101:         ALU_Operation = 4'h3;
      3'b110:         ALU_Operation = 4'h4;
      3'b111:         ALU_Operation = 4'hB;
      default: begin
        case (funct)
          6'b100000:            ALU_Operation = 4'h0;
          6'b100010:            ALU_Operation = 4'h1;
          6'b100100:            ALU_Operation = 4'h2;
          6'b100101:            ALU_Operation = 4'h3;
          6'b100110:            ALU_Operation = 4'h4;
          6'b100111:            ALU_Operation = 4'h5;
          6'b101010:            ALU_Operation = 4'h6;
          6'b101011:            ALU_Operation = 4'h7;
          6'b000000, 6'b000100: ALU_Operation = 4'h8;
          6'b000010, 6'b000110: ALU_Operation = 4'h9;
          6'b000011, 6'b000111: ALU_Operation = 4'hA;
          6'b001000:            ALU_Operation = 4'h0;
          default:              w_unknown = !(w_isMd || w_isMf || w_isMt);
        endcase
      end
    endcase
  end

  assign illegal = valid && w_rtype && w_unknown;

  // Engine FSM: accept in IDLE, iterate WIDTH steps, then FIX for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_prod  <= '0;
      r_opB   <= '0;
      r_isDiv <= 1'b0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_isDiv <= w_isDivOp;
            r_negQ  <= w_rsNeg ^ w_rtNeg;
            if (w_isDivOp) begin
              r_negR <= w_rsNeg;
              r_opB  <= w_rtMag;
              if (w_divZero) begin
                r_negQ  <= 1'b0;
                r_negR  <= 1'b0;
                r_prod  <= {rs_val, {WIDTH{1'b1}}};
                r_count <= '0;
                r_state <= S_FIX;
              end else begin
                r_prod  <= {{WIDTH{1'b0}}, w_rsMag};
                r_count <= CNT_LOAD;
                r_state <= S_DIV;
              end
            end else begin
              r_negR  <= 1'b0;
              r_opB   <= w_rsMag;
              r_prod  <= {{WIDTH{1'b0}}, w_rtMag};
              r_count <= CNT_LOAD;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
          r_count <= r_count - CNT_ONE;
          if (r_count == CNT_ONE) r_state <= S_FIX;
        end
        S_DIV: begin
          if (!w_diff[WIDTH]) r_prod <= {w_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
          else                r_prod <= {w_remShift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
          r_count <= r_count - CNT_ONE;
          if (r_count == CNT_ONE) r_state <= S_FIX;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // HI/LO: written by FIX results or by MTHI/MTLO when not stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_mdEn && (r_state == S_FIX)) begin
      r_hi <= w_fixHi;
      r_lo <= w_fixLo;
    end else if (w_mtWrite) begin
      if (funct[1]) r_lo <= rs_val;
      else          r_hi <= rs_val;
    end
  end

endmodule

// File: tb/tb_ula_ctrl_md.sv
// tb_ula_ctrl_md: scenario tasks for decode, multiply/divide, stalls,
// MT/MF and reset, with an expected-result queue for engine operations.
module tb_ula_ctrl_md;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [2:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [3:0]  ALU_Operation;
  logic        illegal;
  logic        stall;
  logic        md_busy;
  logic [31:0] mf_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int nTests = 0;
  int nFail  = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } mdExp_t;

  mdExp_t sbQ[$];

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  ula_ctrl_md #(.WIDTH(32), .MD_ENABLE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .ALUOp        (ALUOp),
    .funct        (funct),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .ALU_Operation(ALU_Operation),
    .illegal      (illegal),
    .stall        (stall),
    .md_busy      (md_busy),
    .mf_data      (mf_data),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hang guard
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model computed with plain 64-bit / integer arithmetic
  function automatic mdExp_t modelMd(input logic [5:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    mdExp_t             e;
    logic [63:0]        p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    int                 si;
    int                 sj;
    e.busy = 33;
    e.hi   = 32'h0;
    e.lo   = 32'h0;
    case (f)
      F_MULT: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = sa * sb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      F_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      F_DIV: begin
        if (b == 32'h0) begin
          e.hi = a; e.lo = 32'hFFFFFFFF; e.busy = 1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          e.hi = 32'h0; e.lo = 32'h80000000;
        end else begin
          si = a;
          sj = b;
          e.lo = si / sj;
          e.hi = si % sj;
        end
      end
      F_DIVU: begin
        if (b == 32'h0) begin
          e.hi = a; e.lo = 32'hFFFFFFFF; e.busy = 1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: begin
        e.busy = 0;
      end
    endcase
    return e;
  endfunction

  task automatic idleInputs();
    valid = 1'b0;
    ALUOp = 3'b000;
    funct = 6'b000000;
  endtask

  // Present an MD op at the current (post-edge) phase, record its expectation,
  // step through the accept edge, then scramble operands to prove they were latched
  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    valid  = 1'b1;
    ALUOp  = 3'b010;
    funct  = f;
    rs_val = a;
    rt_val = b;
    sbQ.push_back(modelMd(f, a, b));
    @(posedge clk); #1;
    idleInputs();
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Count consecutive sampled cycles where md_busy (which=0) or stall (which=1) is high
  task automatic countHigh(input int which, output int cnt);
    cnt = 0;
    while (((which == 0) ? md_busy : stall) && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    rs_val = 32'h0;
    rt_val = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    nTests++;
    if (md_busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy got %b want 0", md_busy); end
    nTests++;
    if (stall !== 1'b0) begin nFail++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    nTests++;
    if (hi_out !== 32'h0) begin nFail++; $display("[TB] FAIL reset_hi got %h want 0", hi_out); end
    nTests++;
    if (lo_out !== 32'h0) begin nFail++; $display("[TB] FAIL reset_lo got %h want 0", lo_out); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [5:0] fn;
    logic       vld;
    logic [3:0] expOp;
    logic       expIll;
  } decVec_t;

  task automatic test_decode();
    decVec_t tbl[17] = '{
      '{3'b111, 6'b000000, 1'b1, 4'hB, 1'b0},
      '{3'b010, 6'b000111, 1'b1, 4'hA, 1'b0},
      '{3'b010, 6'b101011, 1'b1, 4'h7, 1'b0},
      '{3'b010, 6'b111111, 1'b1, 4'h0, 1'b1},
      '{3'b010, 6'b001000, 1'b1, 4'h0, 1'b0},
      '{3'b000, 6'b000000, 1'b1, 4'h0, 1'b0},
      '{3'b001, 6'b000000, 1'b1, 4'h1, 1'b0},
      '{3'b100, 6'b000000, 1'b1, 4'h2, 1'b0},
      '{3'b101, 6'b000000, 1'b1, 4'h3, 1'b0},
      '{3'b110, 6'b000000, 1'b1, 4'h4, 1'b0},
      '{3'b011, 6'b111111, 1'b1, 4'h0, 1'b0},
      '{3'b010, 6'b100111, 1'b1, 4'h5, 1'b0},
      '{3'b010, 6'b101010, 1'b1, 4'h6, 1'b0},
      '{3'b010, 6'b000100, 1'b1, 4'h8, 1'b0},
      '{3'b010, 6'b000110, 1'b1, 4'h9, 1'b0},
      '{3'b010, 6'b111111, 1'b0, 4'h0, 1'b0},
      '{3'b010, 6'b010000, 1'b1, 4'h0, 1'b0}
    };
    for (int i = 0; i < 17; i++) begin
      valid = tbl[i].vld;
      ALUOp = tbl[i].op;
      funct = tbl[i].fn;
      #1;
      nTests++;
      if (ALU_Operation !== tbl[i].expOp) begin
        nFail++;
        $display("[TB] FAIL decode_op[%0d] got %h want %h", i, ALU_Operation, tbl[i].expOp);
      end
      nTests++;
      if (illegal !== tbl[i].expIll) begin
        nFail++;
        $display("[TB] FAIL decode_illegal[%0d] got %b want %b", i, illegal, tbl[i].expIll);
      end
      nTests++;
      if (stall !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL decode_stall[%0d] got %b want 0", i, stall);
      end
      @(posedge clk); #1;
    end
    idleInputs();
  endtask

  // Multiply and divide results plus busy duration, including divide-by-zero and overflow
  task automatic test_muldiv();
    logic [5:0]  fT[9] = '{F_MULT, F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIV, F_DIV, F_DIVU, F_MULT};
    logic [31:0] aT[9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9, 32'h00000064,
                           32'h80000000, 32'h00000007, 32'hFFFFFFFF, 32'h0};
    logic [31:0] bT[9] = '{32'h00000007, 32'hFFFFFFFF, 32'h80000000, 32'h00000002, 32'h00000000,
                           32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0000000A, 32'h0};
    mdExp_t      e;
    int          cnt;
    aT[8] = $urandom;
    bT[8] = $urandom;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(fT[i], aT[i], bT[i]);
      countHigh(0, cnt);
      e = sbQ.pop_front();
      nTests++;
      if (cnt !== e.busy) begin
        nFail++;
        $display("[TB] FAIL md_busy_cycles[%0d] got %0d want %0d", i, cnt, e.busy);
      end
      nTests++;
      if (hi_out !== e.hi) begin
        nFail++;
        $display("[TB] FAIL md_hi[%0d] got %h want %h", i, hi_out, e.hi);
      end
      nTests++;
      if (lo_out !== e.lo) begin
        nFail++;
        $display("[TB] FAIL md_lo[%0d] got %h want %h", i, lo_out, e.lo);
      end
    end
  endtask

  // MFLO issued right after a MULT accept waits for the result
  task automatic test_stall_mf();
    mdExp_t e;
    int     cnt;
    applyStimulus(F_MULT, 32'h00012345, 32'hFFFF0003);
    valid = 1'b1;
    ALUOp = 3'b010;
    funct = F_MFLO;
    #1;
    nTests++;
    if (mf_data !== 32'h0) begin
      nFail++;
      $display("[TB] FAIL mf_while_stalled got %h want 0", mf_data);
    end
    countHigh(1, cnt);
    e = sbQ.pop_front();
    nTests++;
    if (cnt !== 33) begin nFail++; $display("[TB] FAIL mflo_stall_cycles got %0d want 33", cnt); end
    nTests++;
    if (mf_data !== e.lo) begin
      nFail++;
      $display("[TB] FAIL mflo_release_data got %h want %h", mf_data, e.lo);
    end
    nTests++;
    if (hi_out !== e.hi) begin nFail++; $display("[TB] FAIL mflo_hi got %h want %h", hi_out, e.hi); end
    @(posedge clk); #1;
    idleInputs();
  endtask

  // A second MULT during busy is held off, then runs to completion afterwards
  task automatic test_back_to_back();
    mdExp_t e;
    int     cnt;
    applyStimulus(F_MULTU, 32'hDEADBEEF, 32'h00001000);
    valid  = 1'b1;
    ALUOp  = 3'b010;
    funct  = F_MULT;
    rs_val = 32'hFFFFFF00;
    rt_val = 32'h00000300;
    sbQ.push_back(modelMd(F_MULT, 32'hFFFFFF00, 32'h00000300));
    #1;
    countHigh(1, cnt);
    nTests++;
    if (cnt !== 33) begin nFail++; $display("[TB] FAIL b2b_stall_cycles got %0d want 33", cnt); end
    e = sbQ.pop_front();
    nTests++;
    if (hi_out !== e.hi || lo_out !== e.lo) begin
      nFail++;
      $display("[TB] FAIL b2b_first got %h_%h want %h_%h", hi_out, lo_out, e.hi, e.lo);
    end
    @(posedge clk); #1;
    idleInputs();
    rs_val = $urandom;
    rt_val = $urandom;
    countHigh(0, cnt);
    e = sbQ.pop_front();
    nTests++;
    if (cnt !== 33) begin nFail++; $display("[TB] FAIL b2b_second_busy got %0d want 33", cnt); end
    nTests++;
    if (hi_out !== e.hi || lo_out !== e.lo) begin
      nFail++;
      $display("[TB] FAIL b2b_second got %h_%h want %h_%h", hi_out, lo_out, e.hi, e.lo);
    end
  endtask

  task automatic test_mt_mf();
    valid  = 1'b1;
    ALUOp  = 3'b010;
    funct  = F_MTHI;
    rs_val = 32'h12345678;
    @(posedge clk); #1;
    funct  = F_MTLO;
    rs_val = 32'hCAFEF00D;
    @(posedge clk); #1;
    funct  = F_MFHI;
    rs_val = 32'h0;
    #1;
    nTests++;
    if (mf_data !== 32'h12345678) begin
      nFail++;
      $display("[TB] FAIL mfhi_data got %h want 12345678", mf_data);
    end
    funct = F_MFLO;
    #1;
    nTests++;
    if (mf_data !== 32'hCAFEF00D) begin
      nFail++;
      $display("[TB] FAIL mflo_data got %h want cafef00d", mf_data);
    end
    nTests++;
    if (hi_out !== 32'h12345678) begin
      nFail++;
      $display("[TB] FAIL mthi_hi got %h want 12345678", hi_out);
    end
    @(posedge clk); #1;
    idleInputs();
  endtask

  // Reset in the middle of a DIV discards it; a new MULT starts right away
  task automatic test_reset_mid();
    mdExp_t e;
    int     cnt;
    applyStimulus(F_DIV, 32'h000003E8, 32'h00000007);
    void'(sbQ.pop_front());
    repeat (9) @(posedge clk);
    #1;
    nTests++;
    if (md_busy !== 1'b1) begin nFail++; $display("[TB] FAIL midreset_pre_busy got %b want 1", md_busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    nTests++;
    if (md_busy !== 1'b0) begin nFail++; $display("[TB] FAIL midreset_busy got %b want 0", md_busy); end
    nTests++;
    if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
      nFail++;
      $display("[TB] FAIL midreset_hilo got %h_%h want 0_0", hi_out, lo_out);
    end
    reset = 1'b0;
    applyStimulus(F_MULT, 32'h00001234, 32'h00005678);
    countHigh(0, cnt);
    e = sbQ.pop_front();
    nTests++;
    if (cnt !== e.busy) begin
      nFail++;
      $display("[TB] FAIL postreset_busy got %0d want %0d", cnt, e.busy);
    end
    nTests++;
    if (hi_out !== e.hi || lo_out !== e.lo) begin
      nFail++;
      $display("[TB] FAIL postreset_result got %h_%h want %h_%h", hi_out, lo_out, e.hi, e.lo);
    end
  endtask

  // Scenario sequence
  initial begin
    reset  = 1'b1;
    valid  = 1'b0;
    ALUOp  = 3'b000;
    funct  = 6'b000000;
    rs_val = 32'h0;
    rt_val = 32'h0;
    test_reset();
    test_decode();
    test_muldiv();
    test_stall_mf();
    test_back_to_back();
    test_mt_mf();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
